// File: rtl/traffic_light_monitor_pkg.sv
// rtl/traffic_light_monitor_pkg.sv - lamp, state and error encodings shared by the monitor
package traffic_light_monitor_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b100;

    localparam int RUN_W = 7;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_HW_G = 3'd1,
        ST_HW_Y = 3'd2,
        ST_AR1  = 3'd3,
        ST_LR_G = 3'd4,
        ST_LR_Y = 3'd5,
        ST_AR2  = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ENCODING = 3'd1,
        ERR_CONFLICT = 3'd2,
        ERR_ORDER    = 3'd3,
        ERR_SHORT    = 3'd4,
        ERR_LONG     = 3'd5,
        ERR_NOCAR    = 3'd6
    } err_code_e;

    function automatic logic is_one_hot(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    // {hw_light, lr_light} shown by the controller during a phase
    function automatic logic [5:0] phase_pattern(input state_e s);
        case (s)
            ST_HW_G: return {LAMP_GREEN,  LAMP_RED};
            ST_HW_Y: return {LAMP_YELLOW, LAMP_RED};
            ST_LR_G: return {LAMP_RED,    LAMP_GREEN};
            ST_LR_Y: return {LAMP_RED,    LAMP_YELLOW};
            default: return {LAMP_RED,    LAMP_RED};
        endcase
    endfunction

    function automatic state_e next_phase(input state_e s);
        case (s)
            ST_HW_G: return ST_HW_Y;
            ST_HW_Y: return ST_AR1;
            ST_AR1:  return ST_LR_G;
            ST_LR_G: return ST_LR_Y;
            ST_LR_Y: return ST_AR2;
            ST_AR2:  return ST_HW_G;
            default: return ST_SYNC;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_run_counter.sv
// rtl/traffic_light_monitor_run_counter.sv - saturating count of consecutive samples of one pattern
module traffic_light_monitor_run_counter
    import traffic_light_monitor_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    output logic [RUN_W-1:0] run
);

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    // clr restarts at 1 because the sample that changed the pattern is its first
    always_comb begin
        run_d = run_q;
        if (clr) begin
            run_d = RUN_W'(1);
        end else if (run_q != {RUN_W{1'b1}}) begin
            run_d = run_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    assign run = run_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - checks a two-road light controller's lamp sequence and timing
module traffic_light_monitor
    import traffic_light_monitor_pkg::*;
#(
    parameter int GREEN_LEN  = 70,
    parameter int YELLOW_LEN = 25,
    parameter int ALLRED_LEN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] hw_light,
    input  logic [2:0] lr_light,
    input  logic       lr_has_car,
    output logic [2:0] phase,
    output logic       err_pulse,
    output logic [2:0] err_code,
    output logic       err_sticky,
    output logic [7:0] err_count
);

    state_e           state_q, state_d;
    logic             car_q;
    logic [RUN_W-1:0] run;
    logic             run_clr;
    logic             err_valid;
    err_code_e        err_sel;
    logic [5:0]       pattern;
    int               fixed_len;
    int               run_len;

    logic             err_pulse_q, err_pulse_d;
    logic [2:0]       err_code_q, err_code_d;
    logic             err_sticky_q, err_sticky_d;
    logic [7:0]       err_count_q, err_count_d;

    assign pattern = {hw_light, lr_light};
    assign run_len = int'(run);

    traffic_light_monitor_run_counter u_run_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_clr),
        .run   (run)
    );

    always_comb begin
        case (state_q)
            ST_HW_Y, ST_LR_Y: fixed_len = YELLOW_LEN;
            ST_AR1, ST_AR2:   fixed_len = ALLRED_LEN;
            default:          fixed_len = GREEN_LEN;
        endcase
    end

    // run holds the length of the current phase before this sample is counted
    always_comb begin
        state_d   = state_q;
        run_clr   = 1'b0;
        err_valid = 1'b0;
        err_sel   = ERR_NONE;
        if (state_q == ST_SYNC) begin
            run_clr = 1'b1;
            if (pattern == {LAMP_GREEN, LAMP_RED}) begin
                state_d = ST_HW_G;
            end
        end else if (!is_one_hot(hw_light) || !is_one_hot(lr_light)) begin
            err_valid = 1'b1;
            err_sel   = ERR_ENCODING;
            state_d   = ST_SYNC;
            run_clr   = 1'b1;
        end else if (hw_light != LAMP_RED && lr_light != LAMP_RED) begin
            err_valid = 1'b1;
            err_sel   = ERR_CONFLICT;
            state_d   = ST_SYNC;
            run_clr   = 1'b1;
        end else if (pattern == phase_pattern(state_q)) begin
            if (state_q != ST_HW_G && run_len == fixed_len) begin
                err_valid = 1'b1;
                err_sel   = ERR_LONG;
            end
        end else if (pattern == phase_pattern(next_phase(state_q))) begin
            state_d = next_phase(state_q);
            run_clr = 1'b1;
            if ((state_q == ST_HW_G) ? (run_len < GREEN_LEN) : (run_len != fixed_len)) begin
                err_valid = 1'b1;
                err_sel   = ERR_SHORT;
            end else if (state_q == ST_HW_G && !car_q) begin
                err_valid = 1'b1;
                err_sel   = ERR_NOCAR;
            end
        end else begin
            err_valid = 1'b1;
            err_sel   = ERR_ORDER;
            state_d   = ST_SYNC;
            run_clr   = 1'b1;
        end
    end

    always_comb begin
        err_pulse_d  = err_valid;
        err_code_d   = err_valid ? err_sel : err_code_q;
        err_sticky_d = err_sticky_q | err_valid;
        err_count_d  = err_count_q;
        if (err_valid && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SYNC;
            car_q        <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= 3'd0;
            err_sticky_q <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            car_q        <= lr_has_car;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign phase      = state_q;
    assign err_pulse  = err_pulse_q;
    assign err_code   = err_code_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed bench for traffic_light_monitor
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] hw_light = R;
    logic [2:0] lr_light = R;
    logic       lr_has_car = 1'b0;
    logic [2:0] phase;
    logic       err_pulse;
    logic [2:0] err_code;
    logic       err_sticky;
    logic [7:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    traffic_light_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hw_light   (hw_light),
        .lr_light   (lr_light),
        .lr_has_car (lr_has_car),
        .phase      (phase),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " phase"},  int'(phase), 0);
        check({tag, " pulse"},  int'(err_pulse), 0);
        check({tag, " code"},   int'(err_code), 0);
        check({tag, " sticky"}, int'(err_sticky), 0);
        check({tag, " count"},  int'(err_count), 0);
    endtask

    // hold one lamp pattern for n samples; outputs read 1 time unit after each edge
    task automatic seg(input string tag, input logic [2:0] hw, input logic [2:0] lr,
                       input logic car, input int n, input int exp_phase, input int exp_pulses);
        int pulses;
        pulses     = 0;
        hw_light   = hw;
        lr_light   = lr;
        lr_has_car = car;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) check({tag, " phase"}, int'(phase), exp_phase);
            if (err_pulse) pulses++;
        end
        check({tag, " pulses"}, pulses, exp_pulses);
    endtask

    task automatic apply_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic lr_half(input string tag);
        seg({tag, " lr_g"}, R, G, 1'b0, 70, 4, 0);
        seg({tag, " lr_y"}, R, Y, 1'b0, 25, 5, 0);
        seg({tag, " ar2"},  R, R, 1'b0, 1,  6, 0);
    endtask

    initial begin
        int pulses;
        apply_reset("reset");

        // nominal cycle
        seg("nom hw_g", G, R, 1'b1, 70, 1, 0);
        seg("nom hw_y", Y, R, 1'b1, 25, 2, 0);
        seg("nom ar1",  R, R, 1'b1, 1,  3, 0);
        lr_half("nom");
        check("nom count", int'(err_count), 0);
        check("nom sticky", int'(err_sticky), 0);

        // yellow one cycle short
        seg("short hw_g", G, R, 1'b1, 70, 1, 0);
        seg("short hw_y", Y, R, 1'b1, 24, 2, 0);
        seg("short ar1",  R, R, 1'b1, 1,  3, 1);
        check("short code", int'(err_code), 4);
        check("short sticky", int'(err_sticky), 1);
        check("short count", int'(err_count), 1);
        lr_half("short");

        // car sensor low on the last highway-green sample
        seg("nocar hw_g", G, R, 1'b1, 69, 1, 0);
        seg("nocar last", G, R, 1'b0, 1,  1, 0);
        seg("nocar hw_y", Y, R, 1'b1, 1,  2, 1);
        check("nocar code", int'(err_code), 6);
        check("nocar count", int'(err_count), 2);
        seg("nocar hw_y2", Y, R, 1'b1, 24, 2, 0);

        // both roads non-red during highway yellow, then resync
        seg("conflict", Y, G, 1'b1, 1, 0, 1);
        check("conflict code", int'(err_code), 2);
        check("conflict count", int'(err_count), 3);
        seg("sync wait", R, R, 1'b1, 3, 0, 0);
        seg("resync hw_g", G, R, 1'b1, 70, 1, 0);
        seg("resync hw_y", Y, R, 1'b1, 25, 2, 0);
        seg("resync ar1",  R, R, 1'b1, 1,  3, 0);
        lr_half("resync");

        // yellow held past its length: flagged on the 26th sample
        seg("long hw_g", G, R, 1'b1, 70, 1, 0);
        seg("long hw_y", Y, R, 1'b1, 25, 2, 0);
        seg("long extra", Y, R, 1'b1, 1, 2, 1);
        check("long code", int'(err_code), 5);
        check("long count", int'(err_count), 4);

        apply_reset("reset2");

        // encoding and conflict together: lowest code only
        seg("enc hw_g", G, R, 1'b1, 1, 1, 0);
        seg("enc bad", 3'b011, G, 1'b1, 1, 0, 1);
        check("enc code", int'(err_code), 1);
        check("enc count", int'(err_count), 1);
        check("enc sticky", int'(err_sticky), 1);
        seg("enc after", R, R, 1'b1, 1, 0, 0);

        // 260 further violations saturate the counter
        pulses = 0;
        for (int i = 0; i < 260; i++) begin
            hw_light = G; lr_light = R;
            @(posedge clk); #1;
            hw_light = Y; lr_light = G;
            @(posedge clk); #1;
            if (err_pulse) pulses++;
        end
        check("sat pulses", pulses, 260);
        check("sat count", int'(err_count), 255);
        check("sat code", int'(err_code), 2);

        seg("sat hw_g", G, R, 1'b1, 70, 1, 0);
        seg("sat hw_y", Y, R, 1'b1, 25, 2, 0);
        seg("sat ar1",  R, R, 1'b1, 1,  3, 0);
        seg("sat lr_g", R, G, 1'b0, 10, 4, 0);
        check("sat hold", int'(err_count), 255);

        apply_reset("mid reset");
        seg("post hw_g", G, R, 1'b1, 1, 1, 0);
        check("post count", int'(err_count), 0);
        check("post sticky", int'(err_sticky), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
